// File: rtl/frame_buffer_dbl.sv
`timescale 1ns/1ps
// frame_buffer_dbl
//   Double-buffered, parametrised frame buffer with two pages.
//   Port A (processor) reads and writes the back page one word at a time.
//   Port B (display) reads single pixels from the front page.
//   A swap request is held pending and only takes effect on a frame-boundary
//   strobe, so the display never shows a half-drawn frame.
//   A clear engine fills the back page with a constant word, one word per cycle.
// Ports
//   CLK, RESET            single clock, synchronous active-high reset
//   A_ADDR, A_DATA_IN     back-page {Y,X} address and write word
//   A_WE, A_DATA_OUT      write enable, registered read word (1-cycle latency)
//   A_BUSY                clear engine running
//   CLEAR_REQ, CLEAR_VAL  start a clear of the back page with this word
//   SWAP_REQ, VSYNC_START swap request, frame-boundary strobe
//   SWAP_PENDING          swap requested but not yet performed
//   FRONT_PAGE            page currently shown on port B
//   B_ADDR, B_DATA_OUT    front-page {Y,X} pixel address, registered pixel
module frame_buffer_dbl #(
  parameter int ADDR_X_W = 8,
  parameter int ADDR_Y_W = 7,
  parameter int BPP      = 1,
  parameter int BUS_W    = 8
) (
  input  logic                         CLK,
  input  logic                         RESET,
  input  logic [ADDR_X_W+ADDR_Y_W-1:0] A_ADDR,
  input  logic [BUS_W-1:0]             A_DATA_IN,
  input  logic                         A_WE,
  output logic [BUS_W-1:0]             A_DATA_OUT,
  output logic                         A_BUSY,
  input  logic                         CLEAR_REQ,
  input  logic [BUS_W-1:0]             CLEAR_VAL,
  input  logic                         SWAP_REQ,
  input  logic                         VSYNC_START,
  output logic                         SWAP_PENDING,
  output logic                         FRONT_PAGE,
  input  logic [ADDR_X_W+ADDR_Y_W-1:0] B_ADDR,
  output logic [BPP-1:0]               B_DATA_OUT
);

  localparam int AW    = ADDR_X_W + ADDR_Y_W;
  localparam int PPW   = BUS_W / BPP;
  localparam int SEL_W = $clog2(PPW);
  localparam int WIW   = AW - SEL_W;
  localparam int WORDS = 2 ** WIW;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t           state_q, state_d;
  logic [WIW-1:0]   cnt_q;
  logic [BUS_W-1:0] fill_q;
  logic             front_q;
  logic             pend_q;
  logic             pend_n;

  logic [BUS_W-1:0] mem [0:2*WORDS-1];

  logic [WIW-1:0]   a_widx;
  logic [WIW-1:0]   b_widx;
  int unsigned      b_sel;
  logic [BUS_W-1:0] b_word;
  logic [BPP-1:0]   b_pix;

  logic             mem_we;
  logic [WIW:0]     mem_waddr;
  logic [BUS_W-1:0] mem_wdata;

  // Word index = {Y, X without its pixel-select bits}; built by shifting so the
  // expression stays legal when a word holds a single pixel (SEL_W = 0).
  always_comb begin
    a_widx = WIW'((32'(A_ADDR[AW-1:ADDR_X_W]) << (ADDR_X_W - SEL_W)) |
                  (32'(A_ADDR[ADDR_X_W-1:0]) >> SEL_W));
    b_widx = WIW'((32'(B_ADDR[AW-1:ADDR_X_W]) << (ADDR_X_W - SEL_W)) |
                  (32'(B_ADDR[ADDR_X_W-1:0]) >> SEL_W));
    b_sel  = 32'(B_ADDR[ADDR_X_W-1:0]) % 32'(PPW);
    b_word = mem[{front_q, b_widx}];
    b_pix  = BPP'(b_word >> (b_sel * 32'(BPP)));
  end

  always_comb begin
    state_d   = state_q;
    mem_we    = 1'b0;
    mem_waddr = {~front_q, a_widx};
    mem_wdata = A_DATA_IN;
    case (state_q)
      IDLE: begin
        mem_we = A_WE;
        if (CLEAR_REQ) state_d = CLEAR;
      end
      CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = {~front_q, cnt_q};
        mem_wdata = fill_q;
        if (cnt_q == '1) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A reset during a clear must not commit the word addressed in that cycle.
  always_ff @(posedge CLK) begin
    if (mem_we && !RESET) mem[mem_waddr] <= mem_wdata;
  end

  assign pend_n = pend_q | SWAP_REQ;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      fill_q     <= '0;
      front_q    <= 1'b0;
      pend_q     <= 1'b0;
      A_DATA_OUT <= '0;
      B_DATA_OUT <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && CLEAR_REQ) begin
        fill_q <= CLEAR_VAL;
        cnt_q  <= '0;
      end else if (state_q == CLEAR) begin
        cnt_q <= cnt_q + 1'b1;
      end
      // Read-before-write: returns the old word on a same-address write.
      if (state_q == IDLE) A_DATA_OUT <= mem[{~front_q, a_widx}];
      B_DATA_OUT <= b_pix;
      if (pend_n && VSYNC_START && state_q == IDLE) begin
        front_q <= ~front_q;
        pend_q  <= 1'b0;
      end else begin
        pend_q <= pend_n;
      end
    end
  end

  assign A_BUSY       = (state_q == CLEAR);
  assign SWAP_PENDING = pend_q;
  assign FRONT_PAGE   = front_q;

endmodule

// File: tb/tb_frame_buffer_dbl.sv
`timescale 1ns/1ps
module tb_frame_buffer_dbl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // default instance: 160x120-class, 1 bpp, 8-bit bus, 4096 words/page
  logic        d_rst, d_we, d_clr_req, d_swap_req, d_vsync;
  logic [14:0] d_a_addr, d_b_addr;
  logic [7:0]  d_a_din, d_clr_val, d_a_dout;
  logic        d_busy, d_pend, d_front;
  logic [0:0]  d_b_dout;

  // 4 bpp instance, 16384 words/page
  logic        e_rst, e_we, e_clr_req, e_swap_req, e_vsync;
  logic [14:0] e_a_addr, e_b_addr;
  logic [7:0]  e_a_din, e_clr_val, e_a_dout;
  logic        e_busy, e_pend, e_front;
  logic [3:0]  e_b_dout;

  frame_buffer_dbl d_dut (
    .CLK(clk), .RESET(d_rst), .A_ADDR(d_a_addr), .A_DATA_IN(d_a_din), .A_WE(d_we),
    .A_DATA_OUT(d_a_dout), .A_BUSY(d_busy), .CLEAR_REQ(d_clr_req), .CLEAR_VAL(d_clr_val),
    .SWAP_REQ(d_swap_req), .VSYNC_START(d_vsync), .SWAP_PENDING(d_pend),
    .FRONT_PAGE(d_front), .B_ADDR(d_b_addr), .B_DATA_OUT(d_b_dout)
  );

  frame_buffer_dbl #(.BPP(4), .BUS_W(8)) e_dut (
    .CLK(clk), .RESET(e_rst), .A_ADDR(e_a_addr), .A_DATA_IN(e_a_din), .A_WE(e_we),
    .A_DATA_OUT(e_a_dout), .A_BUSY(e_busy), .CLEAR_REQ(e_clr_req), .CLEAR_VAL(e_clr_val),
    .SWAP_REQ(e_swap_req), .VSYNC_START(e_vsync), .SWAP_PENDING(e_pend),
    .FRONT_PAGE(e_front), .B_ADDR(e_b_addr), .B_DATA_OUT(e_b_dout)
  );

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_v;
  logic [7:0] mdl [2][4096];
  int mfront;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [14:0] waddr(input int w);
    return 15'(((w >> 5) << 8) | ((w & 31) << 3));
  endfunction

  task automatic test_reset;
    d_rst = 1; d_we = 0; d_clr_req = 0; d_swap_req = 0; d_vsync = 0;
    d_a_addr = '0; d_b_addr = '0; d_a_din = '0; d_clr_val = '0;
    e_rst = 1; e_we = 0; e_clr_req = 0; e_swap_req = 0; e_vsync = 0;
    e_a_addr = '0; e_b_addr = '0; e_a_din = '0; e_clr_val = '0;
    tick; tick;
    checks++; if (d_front !== 1'b0) begin errors++; $display("FAIL reset_front got %0b want 0", d_front); end
    checks++; if (d_pend !== 1'b0) begin errors++; $display("FAIL reset_pend got %0b want 0", d_pend); end
    checks++; if (d_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", d_busy); end
    checks++; if (d_a_dout !== 8'h00) begin errors++; $display("FAIL reset_a_dout got %h want 00", d_a_dout); end
    checks++; if (d_b_dout !== 1'b0) begin errors++; $display("FAIL reset_b_dout got %h want 0", d_b_dout); end
    checks++; if (e_front !== 1'b0 || e_busy !== 1'b0 || e_pend !== 1'b0) begin
      errors++; $display("FAIL reset_e_ctrl got front=%0b busy=%0b pend=%0b want 0 0 0", e_front, e_busy, e_pend);
    end
    checks++; if (e_a_dout !== 8'h00 || e_b_dout !== 4'h0) begin
      errors++; $display("FAIL reset_e_data got a=%h b=%h want 00 0", e_a_dout, e_b_dout);
    end
    d_rst = 0; e_rst = 0;
    mfront = 0;
  endtask

  task automatic test_write_read;
    // {Y=3,X=16} -> word 3*32+2 = 98
    d_a_addr = 15'h310; d_a_din = 8'hA5; d_we = 1;
    tick;
    mdl[1-mfront][98] = 8'hA5;
    d_we = 0;
    exp_q.push_back(mdl[1-mfront][98]);
    tick;
    exp_v = exp_q.pop_front();
    checks++; if (d_a_dout !== exp_v) begin errors++; $display("FAIL a_read got %h want %h", d_a_dout, exp_v); end
    // read-during-write returns the old word
    d_a_addr = 15'h000; d_a_din = 8'h11; d_we = 1;
    tick;
    mdl[1-mfront][0] = 8'h11;
    d_a_din = 8'h22;
    exp_q.push_back(mdl[1-mfront][0]);
    tick;
    mdl[1-mfront][0] = 8'h22;
    exp_v = exp_q.pop_front();
    checks++; if (d_a_dout !== exp_v) begin errors++; $display("FAIL rdw_old got %h want %h", d_a_dout, exp_v); end
    d_we = 0;
    exp_q.push_back(mdl[1-mfront][0]);
    tick;
    exp_v = exp_q.pop_front();
    checks++; if (d_a_dout !== exp_v) begin errors++; $display("FAIL rdw_new got %h want %h", d_a_dout, exp_v); end
  endtask

  task automatic test_swap;
    logic [7:0] w;
    d_swap_req = 1;
    tick;
    d_swap_req = 0;
    checks++; if (d_pend !== 1'b1 || d_front !== 1'b0) begin
      errors++; $display("FAIL swap_pending got pend=%0b front=%0b want 1 0", d_pend, d_front);
    end
    d_vsync = 1;
    tick;
    d_vsync = 0;
    mfront = 1;
    checks++; if (d_pend !== 1'b0 || d_front !== 1'b1) begin
      errors++; $display("FAIL swap_done got pend=%0b front=%0b want 0 1", d_pend, d_front);
    end
    w = mdl[mfront][98];
    for (int i = 0; i < 8; i++) begin
      d_b_addr = 15'h310 + 15'(i);
      exp_q.push_back({7'b0, w[i]});
      tick;
      exp_v = exp_q.pop_front();
      checks++; if (d_b_dout !== exp_v[0]) begin
        errors++; $display("FAIL b_pixel x=%0d got %h want %h", 16 + i, d_b_dout, exp_v[0]);
      end
    end
  endtask

  task automatic test_clear;
    int n;
    int hold_bad;
    logic [7:0] w;
    // known word on the back page to observe A_DATA_OUT holding during clear
    d_a_addr = 15'h000; d_a_din = 8'h5A; d_we = 1;
    tick;
    d_we = 0;
    mdl[1-mfront][0] = 8'h5A;
    d_clr_val = 8'hFF; d_clr_req = 1;
    exp_q.push_back(mdl[1-mfront][0]);
    tick;
    d_clr_req = 0; d_clr_val = 8'h00;
    exp_v = exp_q.pop_front();
    checks++; if (d_a_dout !== exp_v) begin errors++; $display("FAIL clear_start_read got %h want %h", d_a_dout, exp_v); end
    n = 0; hold_bad = 0;
    while (d_busy && n < 10000) begin
      n++;
      d_we = 1; d_a_din = 8'h00;
      d_clr_req = (n == 50);
      if (d_a_dout !== exp_v) hold_bad++;
      tick;
    end
    d_we = 0; d_clr_req = 0;
    if (d_a_dout !== exp_v) hold_bad++;
    checks++; if (n !== 4096) begin errors++; $display("FAIL clear_busy_cycles got %0d want 4096", n); end
    checks++; if (hold_bad !== 0) begin errors++; $display("FAIL clear_hold got %0d bad samples want 0", hold_bad); end
    for (int k = 0; k < 4096; k++) mdl[1-mfront][k] = 8'hFF;
    for (int k = 0; k < 4096; k++) begin
      d_a_addr = waddr(k);
      exp_q.push_back(mdl[1-mfront][k]);
      tick;
      exp_v = exp_q.pop_front();
      checks++; if (d_a_dout !== exp_v) begin errors++; $display("FAIL clear_word %0d got %h want %h", k, d_a_dout, exp_v); end
    end
    w = mdl[mfront][98];
    for (int i = 0; i < 8; i++) begin
      d_b_addr = 15'h310 + 15'(i);
      exp_q.push_back({7'b0, w[i]});
      tick;
      exp_v = exp_q.pop_front();
      checks++; if (d_b_dout !== exp_v[0]) begin errors++; $display("FAIL front_kept98 x=%0d got %h want %h", 16 + i, d_b_dout, exp_v[0]); end
    end
    w = mdl[mfront][0];
    for (int i = 0; i < 8; i++) begin
      d_b_addr = 15'(i);
      exp_q.push_back({7'b0, w[i]});
      tick;
      exp_v = exp_q.pop_front();
      checks++; if (d_b_dout !== exp_v[0]) begin errors++; $display("FAIL front_kept0 x=%0d got %h want %h", i, d_b_dout, exp_v[0]); end
    end
  endtask

  task automatic test_swap_during_clear;
    int n;
    logic [7:0] w;
    d_clr_val = 8'h0F; d_clr_req = 1;
    tick;
    d_clr_req = 0;
    d_swap_req = 1;
    tick;
    d_swap_req = 0;
    repeat (100) tick;
    d_vsync = 1;
    tick;
    d_vsync = 0;
    checks++; if (d_front !== 1'(mfront) || d_pend !== 1'b1) begin
      errors++; $display("FAIL vsync_in_clear got front=%0b pend=%0b want %0d 1", d_front, d_pend, mfront);
    end
    n = 0;
    while (d_busy && n < 10000) begin n++; tick; end
    checks++; if (d_busy !== 1'b0) begin errors++; $display("FAIL clear2_timeout got busy=%0b want 0", d_busy); end
    checks++; if (d_front !== 1'(mfront) || d_pend !== 1'b1) begin
      errors++; $display("FAIL after_clear_pending got front=%0b pend=%0b want %0d 1", d_front, d_pend, mfront);
    end
    for (int k = 0; k < 4096; k++) mdl[1-mfront][k] = 8'h0F;
    d_vsync = 1;
    tick;
    d_vsync = 0;
    mfront = 1 - mfront;
    checks++; if (d_front !== 1'(mfront) || d_pend !== 1'b0) begin
      errors++; $display("FAIL deferred_swap got front=%0b pend=%0b want %0d 0", d_front, d_pend, mfront);
    end
    w = mdl[mfront][0];
    d_b_addr = 15'h000;
    exp_q.push_back({7'b0, w[0]});
    tick;
    exp_v = exp_q.pop_front();
    checks++; if (d_b_dout !== exp_v[0]) begin errors++; $display("FAIL new_front_pixel got %h want %h", d_b_dout, exp_v[0]); end
  endtask

  task automatic test_back_to_back;
    int n;
    int pend_bad;
    logic [7:0] w;
    // swap, strobe and clear all in one cycle: the new back page is cleared
    d_swap_req = 1; d_vsync = 1; d_clr_req = 1; d_clr_val = 8'h33;
    tick;
    d_swap_req = 0; d_vsync = 0; d_clr_req = 0;
    mfront = 1 - mfront;
    checks++; if (d_front !== 1'(mfront) || d_pend !== 1'b0) begin
      errors++; $display("FAIL same_cycle_swap got front=%0b pend=%0b want %0d 0", d_front, d_pend, mfront);
    end
    n = 0; pend_bad = 0;
    while (d_busy && n < 10000) begin
      n++;
      if (d_pend !== 1'b0) pend_bad++;
      tick;
    end
    checks++; if (n !== 4096) begin errors++; $display("FAIL clear3_busy_cycles got %0d want 4096", n); end
    checks++; if (pend_bad !== 0) begin errors++; $display("FAIL pend_asserted got %0d samples want 0", pend_bad); end
    for (int k = 0; k < 4096; k++) mdl[1-mfront][k] = 8'h33;
    for (int k = 0; k < 4096; k += 1365) begin
      d_a_addr = waddr(k);
      exp_q.push_back(mdl[1-mfront][k]);
      tick;
      exp_v = exp_q.pop_front();
      checks++; if (d_a_dout !== exp_v) begin errors++; $display("FAIL new_back_word %0d got %h want %h", k, d_a_dout, exp_v); end
    end
    w = mdl[mfront][98];
    for (int i = 0; i < 8; i++) begin
      d_b_addr = 15'h310 + 15'(i);
      exp_q.push_back({7'b0, w[i]});
      tick;
      exp_v = exp_q.pop_front();
      checks++; if (d_b_dout !== exp_v[0]) begin errors++; $display("FAIL b2b_front x=%0d got %h want %h", 16 + i, d_b_dout, exp_v[0]); end
    end
  endtask

  task automatic test_bpp4;
    e_a_addr = 15'd0; e_a_din = 8'h3C; e_we = 1;
    tick;
    e_we = 0;
    e_swap_req = 1; e_vsync = 1;
    tick;
    e_swap_req = 0; e_vsync = 0;
    checks++; if (e_front !== 1'b1) begin errors++; $display("FAIL bpp4_swap got front=%0b want 1", e_front); end
    e_b_addr = 15'd0;
    exp_q.push_back(8'h0C);
    tick;
    exp_v = exp_q.pop_front();
    checks++; if (e_b_dout !== exp_v[3:0]) begin errors++; $display("FAIL bpp4_x0 got %h want %h", e_b_dout, exp_v[3:0]); end
    e_b_addr = 15'd1;
    exp_q.push_back(8'h03);
    tick;
    exp_v = exp_q.pop_front();
    checks++; if (e_b_dout !== exp_v[3:0]) begin errors++; $display("FAIL bpp4_x1 got %h want %h", e_b_dout, exp_v[3:0]); end
  endtask

  task automatic test_reset_mid_clear;
    // back page is 0; word 100 (X=200) pre-loaded to show where the clear stopped
    e_a_addr = 15'd200; e_a_din = 8'h12; e_we = 1;
    tick;
    e_we = 0;
    e_clr_val = 8'h77; e_clr_req = 1;
    tick;
    e_clr_req = 0;
    repeat (100) tick;
    e_rst = 1;
    tick;
    e_rst = 0;
    checks++; if (e_busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %0b want 0", e_busy); end
    checks++; if (e_front !== 1'b0) begin errors++; $display("FAIL abort_front got %0b want 0", e_front); end
    // reset returned page 0 to the front, so port B shows the partial fill
    for (int x = 0; x < 202; x++) begin
      e_b_addr = 15'(x);
      if (x < 200) exp_q.push_back(8'h07);
      else exp_q.push_back((x == 200) ? 8'h02 : 8'h01);
      tick;
      exp_v = exp_q.pop_front();
      checks++; if (e_b_dout !== exp_v[3:0]) begin errors++; $display("FAIL partial_fill x=%0d got %h want %h", x, e_b_dout, exp_v[3:0]); end
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_write_read;
    test_swap;
    test_clear;
    test_swap_during_clear;
    test_back_to_back;
    test_bpp4;
    test_reset_mid_clear;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
